h80cpu_uart_rx: RTL and testbench

CPU-bus peripheral that receives 8N1 serial data on `uart_rxp`, buffers the bytes in a FIFO, and exposes them to the h80 CPU as readable I/O registers. It is the receive counterpart of the bus-attached UART transmitter. Both sit on the same `ce_n`/`addr`/`rd_n`/`wr_n` I/O bus and run in the `sysclk` domain.

---
 rtl/h80_uart_pkg.sv | 28 ++
 rtl/h80_sync_fifo.sv | 67 ++++++
 rtl/h80cpu_uart_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_h80cpu_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/h80_uart_pkg.sv
// ---------------------------------------------------------------------------
// h80_uart_pkg
// Shared definitions for the h80 bus-attached UART blocks:
//   - CPU I/O register addresses (RXDATA, STATUS)
//   - STATUS register bit positions
//   - receiver state encoding
// ---------------------------------------------------------------------------
package h80_uart_pkg;

  // CPU I/O register map
  localparam int UART_RXDATA_ADDR = 'h0001;
  localparam int UART_STATUS_ADDR = 'h0002;

  // STATUS register bit positions
  localparam int STAT_AVAIL     = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_FULL      = 3;

  // Serial receiver states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage : h80_uart_pkg

// File: rtl/h80_sync_fifo.sv
// ---------------------------------------------------------------------------
// h80_sync_fifo
// Single-clock FIFO with head-of-queue (first-word fall-through) read.
// A pop and a push in the same cycle are both honoured, even when full.
//
// Ports:
//   sysclk     in   clock
//   reset_n    in   synchronous active-low reset (pointers only)
//   push       in   write request; ignored when full unless popping too
//   push_data  in   WIDTH  data to write
//   pop        in   read request; ignored when empty
//   head       out  WIDTH  oldest entry (undefined when empty)
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
// ---------------------------------------------------------------------------
module h80_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A simultaneous pop frees the slot the push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule : h80_sync_fifo

// File: rtl/h80cpu_uart_rx.sv
// ---------------------------------------------------------------------------
// h80cpu_uart_rx
// 8N1 serial receiver on the h80 CPU I/O bus. Received bytes are buffered in
// a FIFO and read through two registers:
//   0x0001 RXDATA (read, pops the head; 0x00 when empty)
//   0x0002 STATUS (read, clears overrun/frame_err on a CPU clock edge)
//          bit0 avail, bit1 overrun, bit2 frame_err, bit3 full
//
// Ports:
//   sysclk    in     block clock
//   reset_n   in     synchronous active-low reset
//   clk       in     CPU bus clock, sampled in the sysclk domain
//   ce_n      in     I/O chip enable, active-low
//   addr      in     ADDR_WIDTH  I/O address
//   rd_n      in     read strobe, active-low
//   wr_n      in     write strobe, active-low (writes are ignored)
//   data      inout  DATA_WIDTH  driven only during a mapped read
//   uart_rxp  in     serial input, idles high
//   int_n     out    interrupt, active-low (only with H80_UART_RX_IRQ_EN)
//
// Build option: define H80_UART_RX_IRQ_EN to add the registered int_n output,
// asserted while data is available or an error flag is set.
// ---------------------------------------------------------------------------
module h80cpu_uart_rx
  import h80_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  ce_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_n,
  input  logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  uart_rxp
`ifdef H80_UART_RX_IRQ_EN
  ,
  output logic                  int_n
`endif
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  // ---------------------------------------------------------------------
  // Synchronizers. Both idle high, so reset them to ones: no false edge
  // is seen when reset releases on an idle line / high bus clock.
  // ---------------------------------------------------------------------
  logic clk_s1, clk_s2, clk_s3;
  logic rx_s1, rx_s2, rx_s3;
  logic clk_rise;
  logic rx_fall;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      {clk_s1, clk_s2, clk_s3} <= 3'b111;
      {rx_s1, rx_s2, rx_s3}    <= 3'b111;
    end else begin
      {clk_s1, clk_s2, clk_s3} <= {clk, clk_s1, clk_s2};
      {rx_s1, rx_s2, rx_s3}    <= {uart_rxp, rx_s1, rx_s2};
    end
  end

  assign clk_rise = clk_s2 && !clk_s3;
  assign rx_fall  = rx_s3 && !rx_s2;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic rd_active;
  logic sel_rxdata;
  logic sel_status;
  logic pop_req;
  logic stat_clear;

  assign rd_active  = !ce_n && !rd_n;
  assign sel_rxdata = rd_active && (addr == ADDR_WIDTH'(UART_RXDATA_ADDR));
  assign sel_status = rd_active && (addr == ADDR_WIDTH'(UART_STATUS_ADDR));

  // One detected bus-clock edge per CPU cycle gives at most one pop.
  assign pop_req    = clk_rise && sel_rxdata;
  assign stat_clear = clk_rise && sel_status;

  // Writes have no effect on this block.
  wire unused_wr_n = wr_n;

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic       push;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] shift;

  h80_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shift),
    .pop       (pop_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bitn, bitn_nx;
  logic [7:0]       shift_nx;
  logic             cnt_zero;
  logic             frame_set;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      bitn  <= bitn_nx;
      shift <= shift_nx;
    end
  end

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a variable unassigned and no latch results.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bitn_nx   = bitn;
    shift_nx  = shift;
    push      = 1'b0;
    frame_set = 1'b0;

    case (state)
      IDLE: begin
        // Edge-triggered: a line held low cannot restart a frame.
        if (rx_fall) begin
          cnt_nx   = CNT_HALF;
          state_nx = START;
        end
      end

      START: begin
        if (!cnt_zero) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (!rx_s2) begin
          cnt_nx   = CNT_FULL;
          bitn_nx  = 3'd0;
          state_nx = DATA;
        end else begin
          // Line back high at mid-start: a glitch, not a frame.
          state_nx = IDLE;
        end
      end

      DATA: begin
        if (!cnt_zero) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          shift_nx[bitn] = rx_s2;
          cnt_nx         = CNT_FULL;
          if (bitn == 3'd7) state_nx = STOP;
          else              bitn_nx  = bitn + 3'd1;
        end
      end

      STOP: begin
        if (!cnt_zero) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          if (rx_s2) push      = 1'b1;
          else       frame_set = 1'b1;
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Error flags. A new error in the same cycle as a STATUS-read clear wins,
  // so an event is never lost between being set and being seen.
  // ---------------------------------------------------------------------
  logic overrun;
  logic frame_err;
  logic overrun_set;

  // Full implies non-empty, so any pop request here is a real pop.
  assign overrun_set = push && fifo_full && !pop_req;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stat_clear)  overrun   <= 1'b0;
      if (overrun_set) overrun   <= 1'b1;
      if (stat_clear)  frame_err <= 1'b0;
      if (frame_set)   frame_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------
  logic [7:0] status_byte;
  logic [7:0] rd_byte;

  always_comb begin
    status_byte                 = '0;
    status_byte[STAT_AVAIL]     = !fifo_empty;
    status_byte[STAT_OVERRUN]   = overrun;
    status_byte[STAT_FRAME_ERR] = frame_err;
    status_byte[STAT_FULL]      = fifo_full;
  end

  always_comb begin
    rd_byte = status_byte;
    if (sel_rxdata) rd_byte = fifo_empty ? 8'h00 : fifo_head;
  end

  assign data = (sel_rxdata || sel_status) ? DATA_WIDTH'(rd_byte)
                                           : {DATA_WIDTH{1'bz}};

`ifdef H80_UART_RX_IRQ_EN
  always_ff @(posedge sysclk) begin
    if (!reset_n) int_n <= 1'b1;
    else          int_n <= !(!fifo_empty || overrun || frame_err);
  end
`endif

endmodule : h80cpu_uart_rx

// File: tb/tb_h80cpu_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_h80cpu_uart_rx
// Directed bench for h80cpu_uart_rx. A byte-queue model tracks what the CPU
// must see; one compare process checks the data bus (and int_n when built
// with H80_UART_RX_IRQ_EN) against it during every read window. Literal
// expectations at each step pin the model itself.
// DIV is 16 (CLK_FREQ = 16 * 115200) to keep frames short.
// ---------------------------------------------------------------------------
module tb_h80cpu_uart_rx;

  localparam int CLK_FREQ = 1843200;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;

  localparam logic [15:0] A_RXDATA = 16'h0001;
  localparam logic [15:0] A_STATUS = 16'h0002;

  logic        sysclk   = 1'b0;
  logic        reset_n  = 1'b0;
  logic        clk      = 1'b0;
  logic        ce_n     = 1'b1;
  logic        rd_n     = 1'b1;
  logic        wr_n     = 1'b1;
  logic        uart_rxp = 1'b1;
  logic [15:0] addr     = '0;
  wire  [7:0]  data;
`ifdef H80_UART_RX_IRQ_EN
  logic        int_n;
`endif

  h80cpu_uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .clk      (clk),
    .ce_n     (ce_n),
    .addr     (addr),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .data     (data),
    .uart_rxp (uart_rxp)
`ifdef H80_UART_RX_IRQ_EN
    ,
    .int_n    (int_n)
`endif
  );

  always #5 sysclk = ~sysclk;

  // ---------------- model ----------------
  logic [7:0] q[$];
  bit         m_ov = 1'b0;
  bit         m_fe = 1'b0;

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (q.size() != 0);
    s[1] = m_ov;
    s[2] = m_fe;
    s[3] = (q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic m_int_n();
    return !((q.size() != 0) || m_ov || m_fe);
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  logic       win = 1'b0;
  logic [7:0] exp_data;

  always @(negedge sysclk) begin
    if (win) begin
      check("bus_data", {24'h0, data}, {24'h0, exp_data});
`ifdef H80_UART_RX_IRQ_EN
      check("int_n", {31'h0, int_n}, {31'h0, m_int_n()});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold_bit(input logic v);
    @(posedge sysclk); #1;
    uart_rxp = v;
    repeat (DIV - 1) @(posedge sysclk);
  endtask

  // Full frame; the model is updated once the stop bit has been sampled.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_ok);
    if (stop_ok) begin
      if (q.size() == DEPTH) m_ov = 1'b1;
      else                   q.push_back(b);
    end else begin
      m_fe = 1'b1;
      hold_bit(1'b1);
    end
  endtask

  // CPU read. With clocked=0 the strobes are presented without a bus-clock
  // edge, which observes the register without side effects.
  task automatic bus_read(input logic [15:0] a, input bit clocked,
                          output logic [7:0] got);
    @(posedge sysclk); #1;
    addr = a;
    ce_n = 1'b0;
    rd_n = 1'b0;
    if (a == A_RXDATA) exp_data = (q.size() != 0) ? q[0] : 8'h00;
    else               exp_data = m_status();
    win = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    got = data;
    @(posedge sysclk); #1;
    win = 1'b0;
    if (clocked) begin
      clk = 1'b1;
      repeat (6) @(posedge sysclk);
      #1;
      if (a == A_RXDATA) begin
        if (q.size() != 0) void'(q.pop_front());
      end else begin
        m_ov = 1'b0;
        m_fe = 1'b0;
      end
      clk = 1'b0;
    end
    ce_n = 1'b1;
    rd_n = 1'b1;
    repeat (6) @(posedge sysclk);
  endtask

  task automatic do_reset();
    @(posedge sysclk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    uart_rxp = 1'b1;
    reset_n  = 1'b1;
    q.delete();
    m_ov = 1'b0;
    m_fe = 1'b0;
    repeat (4) @(posedge sysclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got;

    repeat (4) @(posedge sysclk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge sysclk);

    // Reset state
    bus_read(A_STATUS, 1'b0, got); check("reset_status", got, 8'h00);
    bus_read(A_RXDATA, 1'b0, got); check("reset_rxdata", got, 8'h00);

    // Single byte
    send_byte(8'h55, 1'b1);
    bus_read(A_STATUS, 1'b1, got); check("t1_status", got, 8'h01);
    bus_read(A_RXDATA, 1'b1, got); check("t1_rxdata", got, 8'h55);
    bus_read(A_STATUS, 1'b1, got); check("t1_status2", got, 8'h00);

    // Back-to-back frames
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    bus_read(A_RXDATA, 1'b1, got); check("t2_rd0", got, 8'h41);
    bus_read(A_RXDATA, 1'b1, got); check("t2_rd1", got, 8'h42);
    bus_read(A_RXDATA, 1'b1, got); check("t2_rd2", got, 8'h43);
    bus_read(A_RXDATA, 1'b1, got); check("t2_rd3_empty", got, 8'h00);
    bus_read(A_STATUS, 1'b0, got); check("t2_status", got, 8'h00);

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    bus_read(A_STATUS, 1'b0, got); check("t3_status_full", got, 8'h0B);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_RXDATA, 1'b1, got);
      check("t3_drain", got, 32'(i));
    end
    bus_read(A_STATUS, 1'b1, got); check("t3_status_ov", got, 8'h02);
    bus_read(A_STATUS, 1'b1, got); check("t3_status_clr", got, 8'h00);

    // Framing error, then recovery
    send_byte(8'hA5, 1'b0);
    bus_read(A_STATUS, 1'b0, got); check("t4_status_fe", got, 8'h04);
    send_byte(8'h3C, 1'b1);
    bus_read(A_STATUS, 1'b1, got); check("t4_status", got, 8'h05);
    bus_read(A_RXDATA, 1'b1, got); check("t4_rxdata", got, 8'h3C);

    // Short low glitch must not start a frame
    @(posedge sysclk); #1 uart_rxp = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 uart_rxp = 1'b1;
    repeat (3 * DIV) @(posedge sysclk);
    bus_read(A_STATUS, 1'b0, got); check("t5_status", got, 8'h00);
    bus_read(A_RXDATA, 1'b0, got); check("t5_rxdata", got, 8'h00);

    // Reset during bit 4 of a frame, with a flag and a byte pending
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b1);
    bus_read(A_STATUS, 1'b0, got); check("t6_pre", got, 8'h05);
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b0);
    @(posedge sysclk); #1 uart_rxp = 1'b0;
    repeat (DIV / 2) @(posedge sysclk);
    do_reset();
    repeat (2 * DIV) @(posedge sysclk);
    bus_read(A_STATUS, 1'b0, got); check("t6_after_reset", got, 8'h00);
    send_byte(8'h7E, 1'b1);
    bus_read(A_STATUS, 1'b1, got); check("t6_status", got, 8'h01);
    bus_read(A_RXDATA, 1'b1, got); check("t6_rxdata", got, 8'h7E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_h80cpu_uart_rx
